// File: rtl/fetch_queue.sv
// LC-3b fetch stage: owns the fetch PC, issues single-outstanding I-cache reads, buffers {pc, ir} in a FIFO.
// Optional FETCH_QUEUE_BYPASS_EN: hand a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      PC_INC   = 2,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  output logic [WIDTH-1:0]         icache_address,
  output logic                     icache_read,
  input  logic [WIDTH-1:0]         icache_rdata,
  input  logic                     icache_resp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_new_pc,
  output logic [WIDTH-1:0]         out_ir,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned      AW     = $clog2(DEPTH);
  localparam int unsigned      CW     = AW + 1;
  localparam logic [WIDTH-1:0] LP_INC = WIDTH'(PC_INC);
  localparam logic [CW-1:0]    LP_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SQUASH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] w_fetch_pc_nxt;
  logic [WIDTH-1:0] w_fetch_pc_inc;
  logic [WIDTH-1:0] r_req_addr;
  logic [WIDTH-1:0] w_req_addr_nxt;

  logic [WIDTH-1:0] r_mem_pc [DEPTH];
  logic [WIDTH-1:0] r_mem_ir [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;

  logic w_fifo_valid;
  logic w_resp_ok;
  logic w_bypass;
  logic w_bypass_take;
  logic w_push;
  logic w_pop;
  logic w_space;

  // Handshake and occupancy; a redirect hides the head so nothing pops in the flush cycle.
  always_comb begin
    w_fifo_valid = (r_count != '0);
    w_resp_ok    = (r_state == ST_REQ) && icache_resp && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
    w_bypass     = w_resp_ok && !w_fifo_valid;
`else
    w_bypass     = 1'b0;
`endif
    w_bypass_take = w_bypass && out_ready;
    out_valid     = !redirect && (w_fifo_valid || w_bypass);
    out_pc        = w_bypass ? r_req_addr   : r_mem_pc[r_head];
    out_ir        = w_bypass ? icache_rdata : r_mem_ir[r_head];
    out_new_pc    = out_pc + LP_INC;
    w_pop         = out_valid && out_ready && !w_bypass;
    w_push        = w_resp_ok && !w_bypass_take;
    w_count_nxt   = redirect ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    w_space       = (w_count_nxt < LP_FULL);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    w_fetch_pc_inc = r_fetch_pc + LP_INC;
    case (r_state)
      ST_IDLE: begin
        if (redirect) begin
          w_fetch_pc_nxt = redirect_pc;
          w_req_addr_nxt = redirect_pc;
          w_state_nxt    = ST_REQ;
        end else if (w_space) begin
          w_req_addr_nxt = r_fetch_pc;
          w_state_nxt    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          w_fetch_pc_nxt = redirect_pc;
          if (icache_resp) begin
            w_req_addr_nxt = redirect_pc;
          end else begin
            w_state_nxt = ST_SQUASH;
          end
        end else if (icache_resp) begin
          w_fetch_pc_nxt = w_fetch_pc_inc;
          if (w_space) begin
            w_req_addr_nxt = w_fetch_pc_inc;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_SQUASH: begin
        // The stale read must complete before the new target can be requested.
        if (redirect) begin
          w_fetch_pc_nxt = redirect_pc;
        end
        if (icache_resp) begin
          w_req_addr_nxt = redirect ? redirect_pc : r_fetch_pc;
          w_state_nxt    = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= PC_RESET;
      r_req_addr <= PC_RESET;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_count    <= w_count_nxt;
      if (redirect) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + AW'(1);
        if (w_pop)  r_head <= r_head + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_pc[i] <= '0;
        r_mem_ir[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_pc[r_tail] <= r_req_addr;
      r_mem_ir[r_tail] <= icache_rdata;
    end
  end

  assign icache_read    = (r_state != ST_IDLE);
  assign icache_address = r_req_addr;
  assign count          = r_count;

`ifndef SYNTHESIS
  a_no_push_when_full : assert property (@(posedge clk) disable iff (!reset_n)
    !(w_push && (r_count == LP_FULL)));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, PC_RESET=0x3000, PC_INC=2).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] icache_address;
  logic        icache_read;
  logic [15:0] icache_rdata;
  logic        icache_resp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_new_pc;
  logic [15:0] out_ir;
  logic [2:0]  count;

  int          checks = 0;
  int          failures = 0;
  bit          auto_cache;
  int unsigned cache_lat;
  int unsigned cache_cyc;

  always #5 clk = ~clk;

  fetch_queue #(
    .WIDTH   (16),
    .DEPTH   (4),
    .PC_INC  (2),
    .PC_RESET(16'h3000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .icache_address(icache_address),
    .icache_read   (icache_read),
    .icache_rdata  (icache_rdata),
    .icache_resp   (icache_resp),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_new_pc    (out_new_pc),
    .out_ir        (out_ir),
    .count         (count)
  );

  function automatic logic [15:0] cache_word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Advance to the next low phase; the cache model answers after cache_lat cycles of icache_read.
  task automatic step();
    @(negedge clk);
    redirect    = 1'b0;
    icache_resp = 1'b0;
    if (auto_cache && icache_read) begin
      cache_cyc++;
      if (cache_cyc >= cache_lat) begin
        icache_resp  = 1'b1;
        icache_rdata = cache_word(icache_address);
        cache_cyc    = 0;
      end
    end else begin
      cache_cyc = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    out_ready    = 1'b1;
    icache_resp  = 1'b0;
    icache_rdata = '0;
    auto_cache   = 1'b1;
    cache_lat    = 1;
    cache_cyc    = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    step(); #1;
    checks++; if (icache_read !== 1'b1) begin failures++; $display("FAIL rst_first_read: got %b expected 1", icache_read); end
    checks++; if (icache_address !== 16'h3000) begin failures++; $display("FAIL rst_first_addr: got %h expected 3000", icache_address); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (icache_read !== 1'b0) begin failures++; $display("FAIL rst_read: got %b expected 0", icache_read); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (icache_address !== 16'h3000) begin failures++; $display("FAIL rst_addr: got %h expected 3000", icache_address); end
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      logic [15:0] exp_addr;
      logic [15:0] exp_pc;
      step(); #1;
      exp_addr = 16'h3000 + 16'(2 * i);
      exp_pc   = exp_addr - 16'd2;
      checks++; if (icache_address !== exp_addr) begin failures++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, icache_address, exp_addr); end
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, out_valid); end
        checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, out_pc, exp_pc); end
        checks++; if (out_new_pc !== exp_addr) begin failures++; $display("FAIL seq_new_pc[%0d]: got %h expected %h", i, out_new_pc, exp_addr); end
        checks++; if (out_ir !== cache_word(exp_pc)) begin failures++; $display("FAIL seq_ir[%0d]: got %h expected %h", i, out_ir, cache_word(exp_pc)); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL seq_count[%0d]: got %0d expected 1", i, count); end
      end
    end
  endtask

  task automatic test_full();
    int pushes;
    pushes = 0;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      if (icache_resp) pushes++;
    end
    checks++; if (pushes != 4) begin failures++; $display("FAIL full_pushes: got %0d expected 4", pushes); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d expected 4", count); end
    checks++; if (icache_read !== 1'b0) begin failures++; $display("FAIL full_read: got %b expected 0", icache_read); end
    checks++; if (out_pc !== 16'h3000) begin failures++; $display("FAIL full_head: got %h expected 3000", out_pc); end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [15:0] exp_pc;
      step(); #1;
      exp_pc = 16'h3002 + 16'(2 * k);
      if (k == 0) begin
        checks++; if (icache_address !== 16'h3008) begin failures++; $display("FAIL drain_resume_addr: got %h expected 3008", icache_address); end
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL drain_count: got %0d expected 3", count); end
      end
      checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL drain_pc[%0d]: got %h expected %h", k, out_pc, exp_pc); end
      checks++; if (out_ir !== cache_word(exp_pc)) begin failures++; $display("FAIL drain_ir[%0d]: got %h expected %h", k, out_ir, cache_word(exp_pc)); end
    end
  endtask

  task automatic test_redirect_squash();
    apply_reset();
    cache_lat = 5;
    step(); #1;
    step();
    redirect    = 1'b1;
    redirect_pc = 16'h4000;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sq_valid_redirect: got %b expected 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      checks++; if (icache_address !== 16'h3000) begin failures++; $display("FAIL sq_hold_addr[%0d]: got %h expected 3000", i, icache_address); end
      checks++; if (icache_read !== 1'b1) begin failures++; $display("FAIL sq_hold_read[%0d]: got %b expected 1", i, icache_read); end
    end
    step(); #1;
    checks++; if (icache_address !== 16'h4000) begin failures++; $display("FAIL sq_new_addr: got %h expected 4000", icache_address); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL sq_dropped_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sq_dropped_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 5; i++) begin
      step(); #1;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sq_target_valid: got %b expected 1", out_valid); end
    checks++; if (out_pc !== 16'h4000) begin failures++; $display("FAIL sq_target_pc: got %h expected 4000", out_pc); end
    checks++; if (out_new_pc !== 16'h4002) begin failures++; $display("FAIL sq_target_new_pc: got %h expected 4002", out_new_pc); end
    checks++; if (out_ir !== cache_word(16'h4000)) begin failures++; $display("FAIL sq_target_ir: got %h expected %h", out_ir, cache_word(16'h4000)); end
  endtask

  task automatic test_redirect_coincident();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL co_fill_count: got %0d expected 4", count); end
    auto_cache = 1'b0;
    out_ready  = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (icache_address !== 16'h3008) begin failures++; $display("FAIL co_req_addr: got %h expected 3008", icache_address); end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL co_pre_count: got %0d expected 3", count); end
    step();
    out_ready    = 1'b1;
    icache_resp  = 1'b1;
    icache_rdata = 16'hDEAD;
    redirect     = 1'b1;
    redirect_pc  = 16'h5000;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL co_valid_forced: got %b expected 0", out_valid); end
    step(); #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL co_flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL co_flush_valid: got %b expected 0", out_valid); end
    checks++; if (icache_address !== 16'h5000) begin failures++; $display("FAIL co_next_addr: got %h expected 5000", icache_address); end
    checks++; if (icache_read !== 1'b1) begin failures++; $display("FAIL co_next_read: got %b expected 1", icache_read); end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    step(); #1;
    checks++; if (icache_address !== 16'hFFFE) begin failures++; $display("FAIL wrap_addr0: got %h expected fffe", icache_address); end
    step(); #1;
    checks++; if (icache_address !== 16'h0000) begin failures++; $display("FAIL wrap_addr1: got %h expected 0000", icache_address); end
    checks++; if (out_pc !== 16'hFFFE) begin failures++; $display("FAIL wrap_pc: got %h expected fffe", out_pc); end
    checks++; if (out_new_pc !== 16'h0000) begin failures++; $display("FAIL wrap_new_pc: got %h expected 0000", out_new_pc); end
    step(); #1;
    checks++; if (icache_address !== 16'h0002) begin failures++; $display("FAIL wrap_addr2: got %h expected 0002", icache_address); end
    checks++; if (out_pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc2: got %h expected 0000", out_pc); end
    checks++; if (out_ir !== cache_word(16'h0000)) begin failures++; $display("FAIL wrap_ir2: got %h expected %h", out_ir, cache_word(16'h0000)); end
  endtask

  task automatic test_latency();
    apply_reset();
    auto_cache = 1'b0;
    step();
    icache_resp  = 1'b1;
    icache_rdata = 16'h1234;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL byp_valid: got %b expected 1", out_valid); end
    checks++; if (out_ir !== 16'h1234) begin failures++; $display("FAIL byp_ir: got %h expected 1234", out_ir); end
    checks++; if (out_pc !== 16'h3000) begin failures++; $display("FAIL byp_pc: got %h expected 3000", out_pc); end
    step(); #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL byp_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL byp_after_valid: got %b expected 0", out_valid); end
`else
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_same_cycle_valid: got %b expected 0", out_valid); end
    step(); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid: got %b expected 1", out_valid); end
    checks++; if (out_ir !== 16'h1234) begin failures++; $display("FAIL lat_ir: got %h expected 1234", out_ir); end
    checks++; if (out_pc !== 16'h3000) begin failures++; $display("FAIL lat_pc: got %h expected 3000", out_pc); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL lat_count: got %0d expected 1", count); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    out_ready    = 1'b1;
    icache_resp  = 1'b0;
    icache_rdata = '0;
    auto_cache   = 1'b1;
    cache_lat    = 1;
    cache_cyc    = 0;
    test_reset();
    test_sequential();
    test_full();
    test_redirect_squash();
    test_redirect_coincident();
    test_pc_wrap();
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
